// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC lane accumulator datapath.
// Holds the default element/psum widths, the matching product and psum
// types, and the saturating adder used when MAC_SAT_EN is defined.
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PSUM_W = 24;

  // Wide enough that adding two sign-extended psums can never overflow.
  localparam int SAT_CALC_W = 64;

  typedef logic signed [2*DEF_DATA_W-1:0] prod_t;
  typedef logic signed [DEF_PSUM_W-1:0]   psum_t;

  typedef struct packed {
    logic signed [SAT_CALC_W-1:0] sum;
    logic                         ovf;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the sum to the signed range
  // of a 'width'-bit value. ovf flags that clamping took place.
  function automatic sat_res_t sat_add(input logic signed [SAT_CALC_W-1:0] a,
                                       input logic signed [SAT_CALC_W-1:0] b,
                                       input int unsigned                  width);
    logic signed [SAT_CALC_W-1:0] sum;
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    sat_res_t                     res;
    sum     = a + b;
    hi      = (SAT_CALC_W'(1) <<< (width - 1)) - SAT_CALC_W'(1);
    lo      = ~hi;
    res.sum = sum;
    res.ovf = 1'b0;
    if (sum > hi) begin
      res.sum = hi;
      res.ovf = 1'b1;
    end else if (sum < lo) begin
      res.sum = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational signed reduction of LANES packed products.
// The output is wide enough that the sum of LANES full-scale products
// cannot overflow.
module mac_adder_tree #(
  parameter int LANES  = 4,
  parameter int PROD_W = 16,
  parameter int SUM_W  = PROD_W + $clog2(LANES)
) (
  input  logic [LANES*PROD_W-1:0] prods,
  output logic signed [SUM_W-1:0] sum
);

  // Sign-extend every lane product and add them all together.
  // NOTE: blocking assignments in combinational logic, so each loop pass
  // sees the running sum left by the previous pass.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'($signed(prods[i*PROD_W +: PROD_W]));
    end
  end

endmodule

// File: rtl/mac_lane_acc.sv
// Pipelined LANES-wide signed dot product with psum/accumulator add and
// a valid/ready result port.
//   S1: per-lane products registered with first/last/psum_in.
//   S2: adder-tree dot product registered.
//   Acc: accumulator/beat counter update; a last beat raises out_valid.
// The whole pipeline advances only when the result register is free or
// being consumed, so back-pressure never loses or duplicates a beat.
// Optional feature macro: MAC_SAT_EN (saturating accumulate + out_sat).
module mac_lane_acc
  import mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] ifmap,
  input  logic [LANES*DATA_W-1:0] filter,
  input  logic [PSUM_W-1:0]       psum_in,
  input  logic                    acc_first,
  input  logic                    acc_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PSUM_W-1:0]       out_psum,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    out_sat
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int DOT_W  = PROD_W + $clog2(LANES);

  // Stage 1 registers.
  logic                       s1_valid_q, s1_valid_d;
  logic [LANES*PROD_W-1:0]    s1_prod_q, s1_prod_d;
  logic                       s1_first_q, s1_first_d;
  logic                       s1_last_q, s1_last_d;
  logic signed [PSUM_W-1:0]   s1_psum_q, s1_psum_d;

  // Stage 2 registers.
  logic                       s2_valid_q, s2_valid_d;
  logic signed [DOT_W-1:0]    s2_dot_q, s2_dot_d;
  logic                       s2_first_q, s2_first_d;
  logic                       s2_last_q, s2_last_d;
  logic signed [PSUM_W-1:0]   s2_psum_q, s2_psum_d;

  // Accumulator / result registers.
  logic                       out_valid_q, out_valid_d;
  logic signed [PSUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]           beats_q, beats_d;
  logic                       sat_q, sat_d;

  logic                       adv;
  logic [LANES*PROD_W-1:0]    prod_w;
  logic signed [DOT_W-1:0]    dot_w;
  logic signed [PSUM_W-1:0]   acc_sum;
  logic                       acc_ovf;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !rst;

  assign out_valid = out_valid_q;
  assign out_psum  = acc_q;
  assign out_beats = beats_q;

  // Per-lane signed products, operands sign-extended to full product width.
  always_comb begin
    prod_w = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_w[i*PROD_W +: PROD_W] =
        PROD_W'($signed(ifmap[i*DATA_W +: DATA_W])) *
        PROD_W'($signed(filter[i*DATA_W +: DATA_W]));
    end
  end

  mac_adder_tree #(
    .LANES  (LANES),
    .PROD_W (PROD_W),
    .SUM_W  (DOT_W)
  ) u_adder_tree (
    .prods (s1_prod_q),
    .sum   (dot_w)
  );

  // Base selection plus the dot add, wrapping or clamping as configured.
  always_comb begin
    logic signed [PSUM_W-1:0] base;
    logic signed [PSUM_W-1:0] dot_ext;
`ifdef MAC_SAT_EN
    sat_res_t                 sat_r;
`endif
    base    = s2_first_q ? s2_psum_q : acc_q;
    dot_ext = PSUM_W'(s2_dot_q);
`ifdef MAC_SAT_EN
    sat_r   = sat_add(SAT_CALC_W'(base), SAT_CALC_W'(dot_ext), PSUM_W);
    acc_sum = PSUM_W'(sat_r.sum);
    acc_ovf = sat_r.ovf;
`else
    acc_sum = base + dot_ext;
    acc_ovf = 1'b0;
`endif
  end

  // Next-state for every stage; nothing moves unless the pipeline advances.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_psum_d   = s1_psum_q;
    s2_valid_d  = s2_valid_q;
    s2_dot_d    = s2_dot_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_psum_d   = s2_psum_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    sat_d       = sat_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_prod_d   = prod_w;
      s1_first_d  = acc_first;
      s1_last_d   = acc_last;
      s1_psum_d   = psum_in;
      s2_valid_d  = s1_valid_q;
      s2_dot_d    = dot_w;
      s2_first_d  = s1_first_q;
      s2_last_d   = s1_last_q;
      s2_psum_d   = s1_psum_q;
      out_valid_d = s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        acc_d   = acc_sum;
        beats_d = s2_first_q ? CNT_W'(1) : beats_q + CNT_W'(1);
        sat_d   = (s2_first_q ? 1'b0 : sat_q) | acc_ovf;
      end
    end
  end

  // Pipeline and result registers with synchronous reset.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values. Only valid bits and architectural state are reset;
  // stage data is qualified by its valid bit and needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      beats_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_psum_q   <= s1_psum_d;
      s2_valid_q  <= s2_valid_d;
      s2_dot_q    <= s2_dot_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_psum_q   <= s2_psum_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
    end
  end

`ifdef MAC_SAT_EN
  // Sticky clamp flag for the current accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  assign sat_q = 1'b0;
`endif

  assign out_sat = sat_q;

endmodule

// File: tb/tb_mac_lane_acc.sv
// Self-checking bench for mac_lane_acc: a LANES=4 instance driven by
// directed steps and a LANES=1 instance swept over every 8x8 operand pair.
// Expected results are queued when a beat is accepted and popped when the
// DUT hands a result over.
module tb_mac_lane_acc;

  typedef struct {
    logic [23:0] psum;
    logic [15:0] beats;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  // LANES=4 instance
  logic        in_valid, in_ready, acc_first, acc_last;
  logic [31:0] ifmap, filter;
  logic [23:0] psum_in, out_psum;
  logic        out_valid, out_ready, out_sat;
  logic [15:0] out_beats;
  // LANES=1 instance
  logic        in1_valid, in1_ready, first1, last1;
  logic [7:0]  ifmap1, filter1;
  logic [23:0] psum1_in, out1_psum;
  logic        out1_valid, out1_ready, out1_sat;
  logic [15:0] out1_beats;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic [23:0] m_acc;
  logic [15:0] m_beats;
  logic        m_sat;

  always #5 clk = ~clk;

  mac_lane_acc #(.LANES(4), .DATA_W(8), .PSUM_W(24), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ifmap(ifmap), .filter(filter), .psum_in(psum_in),
    .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_beats(out_beats), .out_sat(out_sat)
  );

  mac_lane_acc #(.LANES(1), .DATA_W(8), .PSUM_W(24), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready),
    .ifmap(ifmap1), .filter(filter1), .psum_in(psum1_in),
    .acc_first(first1), .acc_last(last1),
    .out_valid(out1_valid), .out_ready(out1_ready),
    .out_psum(out1_psum), .out_beats(out1_beats), .out_sat(out1_sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] u24(input longint v);
    return v[23:0];
  endfunction

  // Reference accumulator for the LANES=4 instance.
  task automatic model_beat(input int dot, input logic [23:0] pin, input bit first, input bit last);
    longint s;
    bit     ovf;
    ovf = 1'b0;
    s   = (first ? longint'($signed(pin)) : longint'($signed(m_acc))) + longint'(dot);
`ifdef MAC_SAT_EN
    if (s > 64'sd8388607) begin
      s   = 64'sd8388607;
      ovf = 1'b1;
    end else if (s < -64'sd8388608) begin
      s   = -64'sd8388608;
      ovf = 1'b1;
    end
`endif
    m_acc   = u24(s);
    m_beats = first ? 16'd1 : m_beats + 16'd1;
    m_sat   = (first ? 1'b0 : m_sat) | ovf;
    if (last) q0.push_back('{m_acc, m_beats, m_sat});
  endtask

  // Presents one beat and holds it until accepted; ends just after the accept edge.
  task automatic send(input logic [31:0] ifm, input logic [31:0] flt, input logic [23:0] pin,
                      input bit first, input bit last);
    bit got;
    int dot;
    got = 1'b0;
    ifmap = ifm; filter = flt; psum_in = pin; acc_first = first; acc_last = last;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accepted", 64'(got), 64'(1));
    if (got) begin
      dot = 0;
      for (int i = 0; i < 4; i++)
        dot += int'($signed(ifm[i*8 +: 8])) * int'($signed(flt[i*8 +: 8]));
      model_beat(dot, pin, first, last);
    end
  endtask

  task automatic wait_out(input string tag, input logic [23:0] ep, input logic [15:0] eb, input logic es);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      check({tag, "_psum"}, 64'(out_psum), 64'(ep));
      check({tag, "_beats"}, 64'(out_beats), 64'(eb));
      check({tag, "_sat"}, 64'(out_sat), 64'(es));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
    check("drain_sb0", 64'(q0.size()), 64'(0));
    check("drain_sb1", 64'(q1.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Scoreboard for the LANES=4 instance: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("sb0_expected", 64'(q0.size() != 0), 64'(1));
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("sb0_psum", 64'(out_psum), 64'(e0.psum));
        check("sb0_beats", 64'(out_beats), 64'(e0.beats));
        check("sb0_sat", 64'(out_sat), 64'(e0.sat));
      end
    end
  end

  // Scoreboard for the LANES=1 instance.
  always @(negedge clk) begin
    if (rst === 1'b0 && out1_valid === 1'b1 && out1_ready === 1'b1) begin
      check("sb1_expected", 64'(q1.size() != 0), 64'(1));
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("sb1_psum", 64'(out1_psum), 64'(e1.psum));
        check("sb1_beats", 64'(out1_beats), 64'(e1.beats));
        check("sb1_sat", 64'(out1_sat), 64'(e1.sat));
      end
    end
  end

  initial begin
    logic [23:0] pvals[5];
    logic [7:0]  a, b;
    logic [23:0] c;
    pvals = '{24'hFFFFFF, 24'h000000, 24'h555555, 24'hAAAAAA, 24'h333333};

    rst = 1'b1;
    in_valid = 1'b0; ifmap = '0; filter = '0; psum_in = '0; acc_first = 1'b0; acc_last = 1'b0;
    out_ready = 1'b1;
    in1_valid = 1'b0; ifmap1 = '0; filter1 = '0; psum1_in = '0; first1 = 1'b1; last1 = 1'b1;
    out1_ready = 1'b1;
    m_acc = '0; m_beats = '0; m_sat = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_in1_ready", 64'(in1_ready), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_psum", 64'(out_psum), 64'(0));
    check("rst_out_beats", 64'(out_beats), 64'(0));
    check("rst_out_sat", 64'(out_sat), 64'(0));

    // Single beat, full-scale negative products; result two edges after accept
    send(32'h7F7F7F7F, 32'h80808080, 24'd0, 1'b1, 1'b1);
    check("t1_valid_n0", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_valid_n1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("t1_valid_n2", 64'(out_valid), 64'(1));
    check("t1_psum", 64'(out_psum), 64'(u24(-65024)));
    check("t1_beats", 64'(out_beats), 64'(1));

    // Three-beat accumulation seeded with psum_in=100
    send(32'h04030201, 32'h01010101, 24'd100, 1'b1, 1'b0);
    send(32'h04030201, 32'h01010101, 24'd0, 1'b0, 1'b0);
    send(32'h04030201, 32'h01010101, 24'd0, 1'b0, 1'b1);
    check("t2_valid_n0", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("t2_valid_n1", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("t2_valid_n2", 64'(out_valid), 64'(1));
    check("t2_psum", 64'(out_psum), 64'(130));
    check("t2_beats", 64'(out_beats), 64'(3));
    drain();

    // Back-pressure: result A held for 5 cycles, B in flight, C waiting
    out_ready = 1'b0;
    send(32'h01010101, 32'h02020202, 24'd7, 1'b1, 1'b1);
    send(32'h05050505, 32'h01010101, u24(-3), 1'b1, 1'b1);
    @(posedge clk); #1;
    ifmap = 32'hFEFEFEFE; filter = 32'h03030303; psum_in = 24'd1000;
    acc_first = 1'b1; acc_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_in_ready_stall", 64'(in_ready), 64'(0));
      check("t3_valid_held", 64'(out_valid), 64'(1));
      check("t3_psum_held", 64'(out_psum), 64'(15));
      check("t3_beats_held", 64'(out_beats), 64'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'hFEFEFEFE, 32'h03030303, 24'd1000, 1'b1, 1'b1);
    drain();

    // Positive overflow of the psum range
    send(32'h00000001, 32'h00000001, 24'h7FFFFF, 1'b1, 1'b1);
`ifdef MAC_SAT_EN
    wait_out("t4", 24'h7FFFFF, 16'd1, 1'b1);
`else
    wait_out("t4", 24'h800000, 16'd1, 1'b0);
`endif
    drain();

    // Reset after 2 of 4 beats discards the partial sum and the in-flight beat
    send(32'h01010101, 32'h01010101, 24'd50, 1'b1, 1'b0);
    send(32'h01010101, 32'h01010101, 24'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_in_ready_rst", 64'(in_ready), 64'(0));
    check("t5_valid_rst", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0; m_beats = '0; m_sat = 1'b0;
    check("t5_valid_after", 64'(out_valid), 64'(0));
    check("t5_psum_after", 64'(out_psum), 64'(0));
    check("t5_beats_after", 64'(out_beats), 64'(0));
    send(32'h02020202, 32'h03030303, 24'd5, 1'b1, 1'b1);
    wait_out("t5", 24'd29, 16'd1, 1'b0);

    // Non-first beat continues from the previous result
    send(32'h01010101, 32'h01010101, 24'd12345, 1'b0, 1'b1);
    wait_out("t6", 24'd33, 16'd2, 1'b0);
    drain();

    // LANES=1: every 8x8 pair, psum_in rotating through five patterns
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        a = i[7:0];
        b = j[7:0];
        c = pvals[(i * 256 + j) % 5];
        ifmap1 = a; filter1 = b; psum1_in = c; in1_valid = 1'b1;
        @(negedge clk);
        check("l1_in_ready", 64'(in1_ready), 64'(1));
        if (in1_ready === 1'b1)
          q1.push_back('{u24(longint'($signed(c)) + longint'($signed(a)) * longint'($signed(b))),
                         16'd1, 1'b0});
        @(posedge clk); #1;
      end
    end
    in1_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_lane_acc.md
Name: mac_lane_acc

Overview:
Parametrised, pipelined successor to the single-lane combinational MAC. It computes a LANES-wide signed dot product of ifmap and filter and adds it either to an external psum or to an internal accumulator. Results are emitted through a valid/ready handshake. It is the PE datapath core that the upcoming PE array instantiates per output channel.

Parameters:
LANES, 4, number of parallel ifmap×filter multiplier lanes (≥1)
DATA_W, 8, signed width of each ifmap/filter element
PSUM_W, 24, signed width of psum_in, accumulator and out_psum
CNT_W, 16, width of the accumulated-beat counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
ifmap  in  LANES*DATA_W  packed signed elements, lane 0 in LSBs
filter  in  LANES*DATA_W  packed signed elements, lane 0 in LSBs
psum_in  in  PSUM_W  signed base; used only on a beat with acc_first=1
acc_first  in  1  beat starts a new accumulation (base = psum_in)
acc_last  in  1  beat ends the accumulation (result is emitted)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_psum  out  PSUM_W  signed accumulated result
out_beats  out  CNT_W  number of beats folded into out_psum
out_sat  out  1  saturation occurred in this accumulation (0 unless MAC_SAT_EN)

Behaviour:
- Reset: clk/rst only; rst is synchronous and active-high. While rst=1, in_ready=0. On the next edge: out_valid=0, out_psum=0, out_beats=0, out_sat=0, accumulator=0, all stage valid bits cleared.
- Reset mid-accumulation discards the partial sum. Any in-flight beat is dropped.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv && !rst. A beat is accepted when in_valid && in_ready.
- S1 (register): per-lane signed product, 2*DATA_W bits. Also registers acc_first, acc_last and psum_in.
- S2 (register): dot = signed sum of all lane products, width 2*DATA_W+$clog2(LANES), sign-extended to PSUM_W. Then:
  - acc_next = (first ? psum_in : acc) + dot
  - beats_next = first ? 1 : beats+1; the counter wraps at 2^CNT_W.
- Latency: a beat accepted at edge N updates the accumulator at edge N+2. If that beat has last=1, out_valid rises at N+2.
- Beats with last=0 update the accumulator silently; out_valid is not asserted.
- Holding behaviour: out_psum, out_beats and out_sat hold while out_valid && !out_ready. The whole pipeline stalls; no beat is lost or duplicated.
- out_valid drops on the handshake edge unless a new last beat completes on that same edge, in which case it stays high with the new result.
- first=1 and last=1 on the same beat: single-beat result psum_in+dot, out_beats=1.
- A non-first beat after a completed accumulation continues from the previous result. This is legal, and out_beats keeps counting.
- Arithmetic default: two's-complement wrap modulo 2^PSUM_W.
- LANES=1 must match the legacy MAC exactly: ifmap*filter+psum.

Optional Feature:
MAC_SAT_EN
- Defined: the S2 add is computed at PSUM_W+1 bits and clamped to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]. out_sat is set if any beat of the current accumulation clamped; it clears on the first beat.
- Undefined: results wrap, and out_sat is tied to 0.

Decomposition:
- Shared package mac_pkg holds:
  - default DATA_W/PSUM_W localparams
  - typedefs for the product and psum types
  - function sat_add(a, b) returning a clamped sum plus an overflow flag
- One sub-module is natural: mac_adder_tree, a combinational, parametrised signed reduction of LANES products. It is used in S2.

Test Plan:
- LANES=4, single beat first=last=1, ifmap all 127, filter all -128, psum_in=0 -> out_psum=-65024, out_beats=1, out_valid exactly 2 edges after accept.
- 3 beats, ifmap {1,2,3,4}, filter {1,1,1,1}, psum_in=100 on first, last on beat 3 -> one result, out_psum=130, out_beats=3, out_valid never high earlier.
- Result pending with out_ready=0 for 5 cycles, in_valid held -> in_ready=0 throughout, out_psum stable, next result correct after release (no drop/dup).
- psum_in=0x7FFFFF, product=+1, first=last=1:
  - without macro -> out_psum=0x800000, out_sat=0
  - with MAC_SAT_EN -> out_psum=0x7FFFFF, out_sat=1
- rst=1 for 1 cycle mid-accumulation (after 2 of 4 beats) -> out_valid=0, in_ready=0 during rst; a following fresh first=last beat {2,2,2,2}·{3,3,3,3}, psum_in=5 -> out_psum=29, out_beats=1.
- LANES=1 regression: all 256×256 ifmap/filter pairs × psum_in ∈ {0xFFFFFF, 0, 0x555555, 0xAAAAAA, 0x333333}, first=last=1 -> out_psum == a*b+c (wrap); zero mismatches and no X.
